// File: rtl/sd_spi_cmd_engine.sv
// Single-shot SPI-mode SD command engine: power-up clocks, one command, one R1-style capture.
// Define SD_CRC7_EN to compute the frame CRC7; otherwise the CMD0 constant is used.
module sd_spi_cmd_engine #(
   parameter int CLK_DIV      = 1,
   parameter int POWERUP_CLKS = 80,
   parameter int RESP_TIMEOUT = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  command,
   input  logic [31:0] arg,
   output logic [39:0] response,
   output logic        response_ready,
   input  logic        miso,
   output logic        mosi,
   output logic        sdclk,
   output logic        sd_chip_select,
   output logic [3:0]  state_out
);

   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_POWERUP = 4'd1,
      S_SELECT  = 4'd2,
      S_LOAD    = 4'd3,
      S_SEND    = 4'd4,
      S_WAIT    = 4'd5,
      S_READ    = 4'd6,
      S_RELEASE = 4'd7,
      S_DONE    = 4'd8
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [47:0] frame_q, frame_d;
   logic [39:0] resp_q, resp_d;
   logic        mosi_q, mosi_d;
   logic        sdclk_q, sdclk_d;
   logic        cs_q, cs_d;
   logic        ready_q, ready_d;
   logic        hit_q, hit_d;
   logic        running, tick, rise, fall;
   logic [6:0]  crc;

`ifdef SD_CRC7_EN
   function automatic logic [6:0] crc7_calc(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign crc = crc7_calc({2'b01, command, arg});
`else
   assign crc = 7'h4A;
`endif

   always_comb begin
      running = state_q inside {S_POWERUP, S_SELECT, S_SEND,
                                S_WAIT, S_READ, S_RELEASE};
      tick    = running && (div_q == 16'(CLK_DIV - 1));
      rise    = tick && !sdclk_q;
      fall    = tick && sdclk_q;

      state_d = state_q;
      div_d   = running ? (tick ? 16'd0 : div_q + 16'd1) : 16'd0;
      sdclk_d = tick ? ~sdclk_q : sdclk_q;
      cnt_d   = rise ? cnt_q + 16'd1 : cnt_q;
      frame_d = frame_q;
      resp_d  = resp_q;
      mosi_d  = mosi_q;
      hit_d   = hit_q;

      unique case (state_q)
         S_RESET: state_d = S_POWERUP;
         S_POWERUP: begin
            if (fall && cnt_q == 16'(POWERUP_CLKS)) begin
               state_d = S_SELECT;
               cnt_d   = 16'd0;
            end
         end
         S_SELECT: begin
            if (fall && cnt_q == 16'd8) begin
               state_d = S_LOAD;
               cnt_d   = 16'd0;
               frame_d = {2'b01, command, arg, crc, 1'b1};
            end
         end
         S_LOAD: begin
            state_d = S_SEND;
            mosi_d  = frame_q[47];
         end
         S_SEND: begin
            if (fall) begin
               if (cnt_q == 16'd48) begin
                  state_d = S_WAIT;
                  cnt_d   = 16'd0;
                  mosi_d  = 1'b1;
               end else begin
                  frame_d = {frame_q[46:0], 1'b0};
                  mosi_d  = frame_q[46];
               end
            end
         end
         S_WAIT: begin
            if (rise && !miso) begin
               hit_d  = 1'b1;
               resp_d = {resp_q[38:0], 1'b0};
            end
            if (fall) begin
               if (hit_q) begin
                  state_d = S_READ;
                  cnt_d   = 16'd1;
                  hit_d   = 1'b0;
               end else if (cnt_q == 16'(RESP_TIMEOUT)) begin
                  state_d = S_RELEASE;
                  cnt_d   = 16'd0;
                  resp_d  = '1;
               end
            end
         end
         S_READ: begin
            if (rise) resp_d = {resp_q[38:0], miso};
            if (fall && cnt_q == 16'd40) begin
               state_d = S_RELEASE;
               cnt_d   = 16'd0;
            end
         end
         S_RELEASE: begin
            if (fall && cnt_q == 16'd8) begin
               state_d = S_DONE;
               cnt_d   = 16'd0;
            end
         end
         S_DONE: state_d = S_DONE;
         default: state_d = S_RESET;
      endcase

      // Card is selected from SELECT through the end of the response
      cs_d    = !(state_d inside {S_SELECT, S_LOAD, S_SEND,
                                  S_WAIT, S_READ});
      ready_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RESET;
         div_q   <= 16'd0;
         cnt_q   <= 16'd0;
         frame_q <= 48'd0;
         resp_q  <= 40'd0;
         mosi_q  <= 1'b1;
         sdclk_q <= 1'b0;
         cs_q    <= 1'b1;
         ready_q <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         resp_q  <= resp_d;
         mosi_q  <= mosi_d;
         sdclk_q <= sdclk_d;
         cs_q    <= cs_d;
         ready_q <= ready_d;
         hit_q   <= hit_d;
      end
   end

   assign response       = resp_q;
   assign response_ready = ready_q;
   assign mosi           = mosi_q;
   assign sdclk          = sdclk_q;
   assign sd_chip_select = cs_q;
   assign state_out      = state_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Scoreboard bench for sd_spi_cmd_engine: stimulus queues expectations, monitor compares.
// Build with SD_CRC7_EN to check the computed CRC7 on CMD8.
module tb_sd_spi_cmd_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  command = 6'd0;
   logic [31:0] arg = 32'd0;
   logic [39:0] response;
   logic        response_ready;
   logic        miso = 1'b1;
   logic        mosi;
   logic        sdclk;
   logic        sd_chip_select;
   logic [3:0]  state_out;

   sd_spi_cmd_engine dut (
      .clk(clk),
      .rst(rst),
      .command(command),
      .arg(arg),
      .response(response),
      .response_ready(response_ready),
      .miso(miso),
      .mosi(mosi),
      .sdclk(sdclk),
      .sd_chip_select(sd_chip_select),
      .state_out(state_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic rst_s = 1'b1;

   always @(posedge clk) rst_s <= rst;

`ifdef SD_CRC7_EN
   localparam logic [63:0] FRAME8 = 64'h48_0000_01AA_87;
`else
   localparam logic [63:0] FRAME8 = 64'h48_0000_01AA_95;
`endif

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input string tag, input logic [63:0] val);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: got %h, no expectation queued", tag, val);
      end else begin
         e = sb.pop_front();
         if (e.tag != tag || e.val !== val) begin
            errors++;
            $display("FAIL %s: got %h, expected %s = %h",
                     tag, val, e.tag, e.val);
         end
      end
   endtask

   task automatic wait_fail(input string what);
      checks++;
      errors++;
      $display("FAIL wait_%s: got timeout, expected event", what);
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (state_out == s) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) wait_fail($sformatf("state%0d", s));
   endtask

   task automatic wait_fall();
      bit   ok = 0;
      logic p;
      for (int i = 0; i < 64; i++) begin
         p = sdclk;
         @(posedge clk);
         #1;
         if (p && !sdclk) begin
            ok = 1;
            break;
         end
      end
      if (!ok) wait_fail("sdclk_fall");
   endtask

   task automatic wait_ready(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (response_ready) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) wait_fail("ready");
   endtask

   task automatic drive_resp(input logic [47:0] bits);
      wait_state(4'd5, 1000);
      miso = bits[47];
      for (int i = 46; i >= 0; i--) begin
         wait_fall();
         miso = bits[i];
      end
      wait_fall();
      miso = 1'b1;
   endtask

   task automatic push_run(input logic [63:0] frame,
                           input logic [63:0] resp,
                           input int lat);
      push("pwr", {32'd0, 16'd80, 16'd80});
      push("sel", {32'd0, 16'd8, 16'd8});
      push("seq", 64'h12345);
      push("bits", 64'd48);
      push("frame", frame);
      push("rel", {32'd0, 16'd8, 16'd8});
      push("resp", resp);
      push("cs_rises", 64'd1);
      push("latency", 64'(lat));
      push("done_idle", 64'd0);
   endtask

   task automatic do_reset();
      push("rst_vals", 64'h141);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: turns pin activity into tagged observations
   initial begin
      logic        p_sdclk, p_cs, p_ready, rise;
      logic [3:0]  p_state;
      logic [31:0] seq;
      logic [47:0] fr;
      logic [39:0] done_resp;
      int          cyc, bits, cs_rises, done_cyc, viol;
      int          pwr_t, pwr_g, sel_t, sel_g, rel_t, rel_g;
      bit          rst_seen;
      p_sdclk = 0; p_cs = 1; p_ready = 0; p_state = 0;
      seq = 0; fr = 0; done_resp = 0; rst_seen = 0;
      cyc = 0; bits = 0; cs_rises = 0; done_cyc = 0; viol = 0;
      pwr_t = 0; pwr_g = 0; sel_t = 0; sel_g = 0; rel_t = 0; rel_g = 0;
      forever begin
         @(negedge clk);
         rise = sdclk && !p_sdclk;
         if (rst_s) begin
            if (!rst_seen)
               check("rst_vals", 64'({mosi, sdclk, sd_chip_select,
                     response_ready, state_out, response == 40'd0}));
            rst_seen = 1;
            seq = 0; fr = 0; cyc = 0; bits = 0; cs_rises = 0;
            done_cyc = 0; viol = 0;
            pwr_t = 0; pwr_g = 0; sel_t = 0; sel_g = 0;
            rel_t = 0; rel_g = 0;
         end else begin
            rst_seen = 0;
            cyc++;
            if (rise) begin
               case (state_out)
                  4'd1: begin
                     pwr_t++;
                     if (sd_chip_select && mosi) pwr_g++;
                  end
                  4'd2: begin
                     sel_t++;
                     if (!sd_chip_select && mosi) sel_g++;
                  end
                  4'd4: begin
                     fr = {fr[46:0], mosi};
                     bits++;
                  end
                  4'd7: begin
                     rel_t++;
                     if (sd_chip_select && mosi) rel_g++;
                  end
                  default: ;
               endcase
            end
            if (sd_chip_select && !p_cs) cs_rises++;
            if (state_out != p_state) begin
               seq = {seq[27:0], state_out};
               if (p_state == 4'd1 && state_out == 4'd2)
                  check("pwr", {32'd0, 16'(pwr_t), 16'(pwr_g)});
               if (p_state == 4'd2 && state_out == 4'd3)
                  check("sel", {32'd0, 16'(sel_t), 16'(sel_g)});
               if (p_state == 4'd4 && state_out == 4'd5) begin
                  check("seq", 64'(seq));
                  check("bits", 64'(bits));
                  check("frame", 64'(fr));
               end
               if (p_state == 4'd7 && state_out == 4'd8) begin
                  check("rel", {32'd0, 16'(rel_t), 16'(rel_g)});
                  check("resp", 64'(response));
                  check("cs_rises", 64'(cs_rises));
                  done_resp = response;
                  done_cyc = 0;
                  viol = 0;
               end
            end
            if (response_ready && !p_ready) check("latency", 64'(cyc));
            if (state_out == 4'd8) begin
               done_cyc++;
               if (sdclk || !sd_chip_select || !response_ready ||
                   response !== done_resp) viol++;
               if (done_cyc == 20) check("done_idle", 64'(viol));
            end
         end
         p_sdclk = sdclk;
         p_cs    = sd_chip_select;
         p_ready = response_ready;
         p_state = state_out;
      end
   end

   initial begin
      // CMD0, response after one 0xFF wait byte
      push("rst_vals", 64'h141);
      push_run(64'h40_0000_0000_95, 64'h01_0000_01AA, 386);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      drive_resp(48'hFF_01_0000_01AA);
      wait_ready(1000);
      repeat (30) @(posedge clk);
      #1;

      // CMD0, card never answers; inputs change during SEND
      do_reset();
      command = 6'd0;
      arg = 32'd0;
      miso = 1'b1;
      push_run(64'h40_0000_0000_95, 64'hFF_FFFF_FFFF, 546);
      rst = 1'b0;
      wait_state(4'd4, 1000);
      command = 6'h3F;
      arg = 32'hFFFF_FFFF;
      wait_ready(1500);
      repeat (30) @(posedge clk);
      #1;

      // CMD8 aborted mid-SEND, then a full restart
      do_reset();
      command = 6'd8;
      arg = 32'h1AA;
      push("pwr", {32'd0, 16'd80, 16'd80});
      push("sel", {32'd0, 16'd8, 16'd8});
      rst = 1'b0;
      wait_state(4'd4, 1000);
      repeat (10) @(posedge clk);
      #1;
      do_reset();
      push_run(FRAME8, 64'h01_0000_01AA, 386);
      rst = 1'b0;
      drive_resp(48'hFF_01_0000_01AA);
      wait_ready(1000);
      repeat (30) @(posedge clk);
      #1;

      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: got nothing, expected %h", e.tag, e.val);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_spi_cmd_engine.md
# sd_spi_cmd_engine

Single-shot SD-card command engine for the SPI-mode bring-up path. After reset it performs the power-up clock sequence with chip select high, sends one 48-bit command frame built from `command`/`arg`, and captures a 40-bit response. It then releases the card and holds the result. It sits between the board-level SD pins and the test and bring-up logic that reads `response`.

## Interface
- `CLK_DIV`, default 1: clk cycles per sdclk half-period; sdclk period = 2·CLK_DIV clk.
- `POWERUP_CLKS`, default 80: sdclk cycles with CS high after reset; minimum 74.
- `RESP_TIMEOUT`, default 128: maximum sdclk rising edges spent waiting for the response start bit.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `command` in 6: command index, sampled on entry to LOAD.
- `arg` in 32: command argument, sampled on entry to LOAD.
- `response` out 40: captured response, first received bit in bit 39.
- `response_ready` out 1: high while in DONE.
- `miso` in 1: card data out.
- `mosi` out 1: card data in.
- `sdclk` out 1: SPI clock, idle low (SPI mode 0).
- `sd_chip_select` out 1: active-low card select.
- `state_out` out 4: current state encoding.

## Operation
- Reset values: mosi=1, sdclk=0, sd_chip_select=1, response=0, response_ready=0, state_out=0.
- States and transitions:
  - 0 RESET: next cycle go to 1.
  - 1 POWERUP: CS=1, mosi=1; toggle sdclk for POWERUP_CLKS cycles, then go to 2.
  - 2 SELECT: CS=0, mosi=1; 8 sdclk cycles (0xFF), then go to 3.
  - 3 LOAD: one clk; latch the frame {2'b01, command, arg, crc7, 1'b1}; go to 4.
  - 4 SEND: shift 48 bits MSB first, then go to 5.
  - 5 WAIT_RESP: mosi=1; sample miso on each sdclk rising edge.
    - miso=0: that bit is response[39]; go to 6.
    - After RESP_TIMEOUT edges with no 0: response=40'hFF_FFFF_FFFF; go to 7.
  - 6 READ_RESP: shift in the remaining 39 bits MSB first, then go to 7.
  - 7 RELEASE: CS=1, mosi=1; 8 sdclk cycles, then go to 8.
  - 8 DONE: sdclk stays low, CS=1, response held, response_ready=1 until reset.
- sdclk runs only in states 1, 2, 4, 5, 6 and 7, and stops low.
- Chip select rises exactly once per reset (on entry to RELEASE), not counting reset.
- `command`/`arg` changes after LOAD have no effect.
- Reset in any state aborts immediately and returns all outputs to reset values that cycle.

## Timing
- SPI mode 0:
  - mosi changes on sdclk falling edges.
  - The first frame bit is driven on entry to SEND, before the first rising edge.
  - miso is sampled in the clk cycle where sdclk goes 0→1.
- Bit counters advance on rising edges.
- A state exits on the falling edge that completes its last bit, with sdclk low.
- Latency, reset to response_ready, with no wait bytes: 1 + 1 + (80 + 8 + 48 + 40 + 8)·2·CLK_DIV clk.
  - Each extra WAIT_RESP bit adds 2·CLK_DIV clk.
- state_out equals the registered state, with no delay.

## Configuration
- `SD_CRC7_EN` defined:
  - crc7 is computed over the first 40 frame bits.
  - Polynomial x^7+x^3+1, initial 0.
- Undefined:
  - crc7 is the constant 7'h4A, so the last byte is 0x95, valid for CMD0 with arg 0.
  - This saves logic for CMD0-only bring-up.

## Test plan
- Reset, miso held 1:
  - Exactly 80 sdclk rising edges with CS=1 and mosi=1.
  - Then CS falls, followed by 8 edges with mosi=1.
  - state_out sequence is 0,1,2,3,4,5.
- command=0, arg=0: mosi frame on rising edges = 48'h40_0000_0000_95 (both configs).
- With `SD_CRC7_EN`, command=8, arg=32'h1AA: frame = 48'h48_0000_01AA_87.
- In state 5, miso sends 8'hFF, then 40'h01_0000_01AA:
  - response=40'h01_0000_01AA and response_ready=1.
  - CS rises once, then 8 sdclk cycles, then DONE with sdclk idle.
- miso held 1 in WAIT_RESP: after 128 edges, response=40'hFF_FFFF_FFFF, response_ready=1.
- rst asserted mid-SEND: next cycle CS=1, sdclk=0, mosi=1, state_out=0; the full sequence restarts after rst deasserts.
